mvu_rdc_reader: RTL and testbench

MVU_RDC_READER -- requirements
Module: mvu_rdc_reader

---
 rtl/mvu_rdc_reader.sv | 189 ++++++++++++++++++
 tb/tb_mvu_rdc_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_rdc_reader.sv
// ---------------------------------------------------------------------------
// mvu_rdc_reader
//
// Burst reader for the MVU data bank. A start pulse latches a base address
// and a word count. The block then issues read requests (rdc_en/rdc_addr)
// that are consumed on rdc_grnt. Each consumed request returns rdc_word
// exactly one cycle later. Returned words are buffered in a small FIFO and
// presented on a valid/ready output stream, with out_last marking the final
// word of the burst.
//
// Requests are credit-limited: occupied FIFO entries plus the read in flight
// never exceed FIFO_DEPTH. Returned data is therefore always written into
// the FIFO without a stall path back to the memory.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle burst start (ignored while busy)
//   base_addr, len       burst first address / word count, sampled on start
//   busy                 burst in progress (through the done cycle)
//   done                 one-cycle completion pulse
//   rdc_en, rdc_addr     read request to the MVU data bank
//   rdc_grnt             request consumed when rdc_en & rdc_grnt
//   rdc_word             read data, valid one cycle after a consuming cycle
//   out_valid/out_ready  output handshake
//   out_word, out_last   output data and end-of-burst marker
// ---------------------------------------------------------------------------
module mvu_rdc_reader #(
    parameter int BDBANKA    = 15,
    parameter int BDBANKW    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BDBANKA-1:0] base_addr,
    input  logic [BDBANKA-1:0] len,
    output logic               busy,
    output logic               done,
    output logic               rdc_en,
    output logic [BDBANKA-1:0] rdc_addr,
    input  logic               rdc_grnt,
    input  logic [BDBANKW-1:0] rdc_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BDBANKW-1:0] out_word,
    output logic               out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;  // holds 0..FIFO_DEPTH
    localparam int USE_W = PTR_W + 2;  // headroom for the +/- lookahead
    localparam int LEN_W = BDBANKA + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   req_cnt;
    logic               zero_done_q;

    // One-deep return pipe: data always arrives exactly one cycle after the
    // consuming cycle, so a single flag tracks the read in flight.
    logic               rd_pending;
    logic               rd_pending_last;

    logic [BDBANKW-1:0] fifo_word [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               consume;
    logic               pop;
    logic               last_req;
    logic [USE_W-1:0]   used_next;
    logic               credit_ok;

    assign consume  = rdc_en & rdc_grnt;
    assign pop      = out_valid & out_ready;
    assign last_req = (req_cnt + LEN_W'(1)) == len_q;

    // Credits in use on the next cycle: FIFO entries plus the read in flight,
    // after this cycle's consume and pop take effect. Registering rdc_en from
    // this lookahead keeps it glitch-free and stable while the grant is low.
    assign used_next = USE_W'(fifo_cnt) + USE_W'(rd_pending)
                     + USE_W'(consume) - USE_W'(pop);
    assign credit_ok = used_next < USE_W'(FIFO_DEPTH);

    // Output side reads straight from the FIFO registers. Gating with
    // out_valid keeps out_word/out_last at zero whenever nothing is offered.
    assign out_valid = fifo_cnt != '0;
    assign out_word  = out_valid ? fifo_word[rd_ptr] : '0;
    assign out_last  = out_valid & fifo_last[rd_ptr];

    // A len==0 start completes on the following cycle. A real burst completes
    // in the same cycle its last word is accepted.
    assign done = zero_done_q | ((state == DRAIN) & pop & out_last);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rdc_en      <= 1'b0;
            rdc_addr    <= '0;
            len_q       <= '0;
            req_cnt     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            zero_done_q <= 1'b1;
                        end else begin
                            state    <= READ;
                            busy     <= 1'b1;
                            rdc_en   <= 1'b1;  // FIFO is empty on entry
                            rdc_addr <= base_addr;
                            len_q    <= LEN_W'(len);
                            req_cnt  <= '0;
                        end
                    end
                end
                READ: begin
                    if (consume) begin
                        rdc_addr <= rdc_addr + BDBANKA'(1);  // wraps modulo 2^BDBANKA
                        req_cnt  <= req_cnt + LEN_W'(1);
                    end
                    if (consume && last_req) begin
                        state  <= DRAIN;
                        rdc_en <= 1'b0;
                    end else begin
                        rdc_en <= credit_ok;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return pipe. Clearing it on reset drops a word that lands right after
    // reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
        end else begin
            rd_pending      <= consume;
            rd_pending_last <= consume & last_req;
        end
    end

    // FIFO pointers and occupancy. Simultaneous write and pop on a full FIFO
    // are both honoured: the count is unchanged and both pointers advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rd_pending) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(rd_pending) - CNT_W'(pop);
        end
    end

    // NOTE: the FIFO storage has no reset; its contents are never observed
    // before being written because out_valid comes from the reset count.
    always_ff @(posedge clk) begin
        if (rd_pending) begin
            fifo_word[wr_ptr] <= rdc_word;
            fifo_last[wr_ptr] <= rd_pending_last;
        end
    end

endmodule

// File: tb/tb_mvu_rdc_reader.sv
module tb_mvu_rdc_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [14:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic        rdc_en;
    logic [14:0] rdc_addr;
    logic        rdc_grnt;
    logic [63:0] rdc_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_word;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mvu_rdc_reader #(
        .BDBANKA(15),
        .BDBANKW(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .rdc_en(rdc_en),
        .rdc_addr(rdc_addr),
        .rdc_grnt(rdc_grnt),
        .rdc_word(rdc_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_last(out_last)
    );

    // Memory contents: a recognisable pattern derived from the address.
    function automatic logic [63:0] mem_word(input logic [14:0] a);
        return {16'hC0DE, 1'b0, a, 16'h5A5A, 1'b0, ~a};
    endfunction

    // Memory responder: data for a consumed request appears one cycle later.
    logic        resp_v = 1'b0;
    logic [14:0] resp_a = '0;
    always @(posedge clk) begin
        resp_v <= rdc_en & rdc_grnt;
        resp_a <= rdc_addr;
    end
    assign rdc_word = resp_v ? mem_word(resp_a) : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [14:0] base;
        logic [14:0] len;
        int          gmode;         // 0: grant always, 1: grant toggles 0/1
        int          rmode;         // 0: ready always, 1: ready low 12 cycles, 2: toggle
        bit          poke;          // fire a stray start mid-burst
        int          exp_words;
        logic [14:0] exp_last_addr;
        int          exp_stall_req; // requests consumed while ready is held low
    } vec_t;

    vec_t vecs[7];

    task automatic run_burst(input vec_t v);
        int          nreq;
        int          nout;
        int          stall_req;
        bit          finished;
        logic [14:0] last_addr;
        logic [14:0] exp_a;
        logic        hold_en;
        logic [14:0] hold_addr;
        logic        hold_v;
        logic [63:0] hold_w;
        logic        hold_l;
        logic        exp_last;
        nreq = 0; nout = 0; stall_req = 0; finished = 0;
        last_addr = '0; hold_en = 0; hold_addr = '0; hold_v = 0; hold_w = '0; hold_l = 0;

        @(negedge clk);
        start = 1'b1; base_addr = v.base; len = v.len;
        rdc_grnt = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            start = v.poke && (cyc == 2);
            if (start) begin base_addr = 15'h555; len = 15'd1; end
            rdc_grnt  = (v.gmode == 1) ? cyc[0] : 1'b1;
            out_ready = (v.rmode == 1) ? (cyc >= 12) :
                        (v.rmode == 2) ? ~cyc[0] : 1'b1;
            #1;
            if (cyc == 0) check("busy_rise", busy, 1);
            if (hold_en) begin
                check("req_hold_en", rdc_en, 1);
                check("req_hold_addr", rdc_addr, hold_addr);
            end
            if (hold_v) begin
                check("out_hold_valid", out_valid, 1);
                check("out_hold_word", out_word, hold_w);
                check("out_hold_last", out_last, hold_l);
            end
            hold_en = rdc_en & ~rdc_grnt; hold_addr = rdc_addr;
            hold_v = out_valid & ~out_ready; hold_w = out_word; hold_l = out_last;

            if (rdc_en && rdc_grnt) begin
                exp_a = v.base + 15'(nreq);
                check("req_addr", rdc_addr, exp_a);
                last_addr = rdc_addr;
                nreq++;
                if (cyc < 12) stall_req++;
            end
            if (out_valid && out_ready) begin
                exp_a = v.base + 15'(nout);
                exp_last = (nout + 1) == int'(v.len);
                check("out_word", out_word, mem_word(exp_a));
                check("out_last", out_last, exp_last);
                check("done_with_last", done, exp_last);
                nout++;
            end
            if (done || nout >= int'(v.len)) finished = 1;
            if (!finished) @(negedge clk);
        end
        check("burst_timeout", finished, 1);
        start = 1'b0;
        if (v.rmode == 1) check("stall_requests", stall_req, v.exp_stall_req);
        @(negedge clk);
        #1;
        check("busy_fall", busy, 0);
        check("done_single", done, 0);
        check("rdc_en_idle", rdc_en, 0);
        check("req_count", nreq, v.exp_words);
        check("word_count", nout, v.exp_words);
        check("last_req_addr", last_addr, v.exp_last_addr);
    endtask

    initial begin
        int   nout;
        vec_t r;
        vecs[0] = '{15'h0010, 15'd3, 0, 0, 1'b0, 3, 15'h0012, 0};  // basic
        vecs[1] = '{15'h0100, 15'd8, 0, 1, 1'b0, 8, 15'h0107, 4};  // backpressure
        vecs[2] = '{15'h0200, 15'd5, 1, 0, 1'b0, 5, 15'h0204, 0};  // grant stall
        vecs[3] = '{15'h7FFE, 15'd4, 0, 0, 1'b0, 4, 15'h0001, 0};  // address wrap
        vecs[4] = '{15'h0040, 15'd2, 1, 2, 1'b0, 2, 15'h0041, 0};  // both toggling
        vecs[5] = '{15'h7FFF, 15'd1, 0, 2, 1'b0, 1, 15'h7FFF, 0};  // single word
        vecs[6] = '{15'h0300, 15'd6, 0, 0, 1'b1, 6, 15'h0305, 0};  // start while busy

        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        rdc_grnt = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdc_en", rdc_en, 0);
        check("rst_rdc_addr", rdc_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_word", out_word, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // len == 0: done pulses once the next cycle, no request, busy stays low.
        @(negedge clk);
        start = 1'b1; base_addr = 15'h0123; len = 15'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_rdc_en", rdc_en, 0);
        @(negedge clk);
        #1;
        check("len0_done_once", done, 0);
        check("len0_busy_after", busy, 0);
        check("len0_rdc_en_after", rdc_en, 0);

        // Reset in the middle of a burst, after two words have been delivered.
        @(negedge clk);
        start = 1'b1; base_addr = 15'h0500; len = 15'd8;
        @(negedge clk);
        start = 1'b0; rdc_grnt = 1'b1; out_ready = 1'b1;
        nout = 0;
        for (int cyc = 0; cyc < 50 && nout < 2; cyc++) begin
            #1;
            if (out_valid && out_ready) nout++;
            @(negedge clk);
        end
        check("mid_words_seen", nout, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rdc_en", rdc_en, 0);
        check("mid_rst_rdc_addr", rdc_addr, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_out_word", out_word, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_out_valid0", out_valid, 0);
        @(negedge clk);
        #1;
        check("post_rst_out_valid1", out_valid, 0);
        check("post_rst_busy", busy, 0);
        r = '{15'h0020, 15'd2, 0, 0, 1'b0, 2, 15'h0021, 0};
        run_burst(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
